// File: rtl/cmp_sched_if.sv
// Request/response bundle between the requesters and the shared comparator
// scheduler.
//
// Parameters:
//   NREQ   number of requesters
//   WIDTH  operand width in bits
//
// Signals:
//   req_valid    [NREQ]        per-requester request valid
//   req_ready    [NREQ]        per-requester accept (at most one high)
//   req_a        [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b        [NREQ*WIDTH]  operand B, same packing
//   req_a_signed [NREQ]        operand A is signed
//   req_b_signed [NREQ]        operand B is signed
//   req_op       [NREQ*3]      opcode: 0 LT,1 LE,2 GT,3 GE,4 EQ,5 NE,6/7 reserved
//   rsp_valid                  response valid
//   rsp_ready                  response consumer ready
//   rsp_id       [clog2(NREQ)] requester that issued the request
//   rsp_result                 comparison result
//
// Modports: master = requester/consumer side, slave = scheduler side.
interface cmp_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ-1:0]         req_a_signed;
  logic [NREQ-1:0]         req_b_signed;
  logic [NREQ*3-1:0]       req_op;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic                    rsp_result;

  modport master (
    output req_valid, req_a, req_b, req_a_signed, req_b_signed, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_a_signed, req_b_signed, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one slice-serial magnitude/equality comparator
// between NREQ requesters. The winner's operands are captured, compared SLICE
// bits per cycle from the MSB down, and a 1-bit result is returned tagged with
// the requester id.
//
// Parameters: NREQ (2..8), WIDTH, SLICE (WIDTH must be a multiple of SLICE).
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  cmp_sched_if.slave (request handshake per requester, response handshake)
//
// Build option:
//   CMP_SCHED_EARLY_EXIT_EN  defined: leave CMP at the first differing slice.
//                            undefined: always spend NSLICE cycles in CMP.
module cmp_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input logic        clk,
  input logic        rst,
  cmp_sched_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDW    = $clog2(NREQ);
  localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   grant_id;
  logic             grant_vld;
  logic             accept;
  logic             sgn;
  logic [WIDTH-1:0] msb_flip;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [IDW-1:0]   id_q;
  logic [SW-1:0]    idx;
  logic             lt_q, gt_q;
  logic [SLICE-1:0] a_sl, b_sl;
  logic             sl_diff;

  function automatic logic decode(input logic [2:0] op, input logic lt, input logic gt);
    logic eq;
    eq = !lt && !gt;
    case (op)
      3'd0:    decode = lt;
      3'd1:    decode = lt || eq;
      3'd2:    decode = gt;
      3'd3:    decode = gt || eq;
      3'd4:    decode = eq;
      3'd5:    decode = !eq;
      default: decode = 1'b0;
    endcase
  endfunction

  // Walk offsets from the far end so the candidate closest to the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign accept  = (state == IDLE) && grant_vld && !rst;
  // Offset-binary trick: flipping both sign bits makes a signed compare unsigned.
  assign sgn      = bus.req_a_signed[grant_id] & bus.req_b_signed[grant_id];
  assign msb_flip = {sgn, {(WIDTH-1){1'b0}}};
  assign a_sl     = a_q[idx*SLICE +: SLICE];
  assign b_sl     = b_q[idx*SLICE +: SLICE];
  assign sl_diff  = (a_sl != b_sl);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Operand capture and slice walk; cleared on every accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= bus.req_a[grant_id*WIDTH +: WIDTH] ^ msb_flip;
      b_q  <= bus.req_b[grant_id*WIDTH +: WIDTH] ^ msb_flip;
      op_q <= bus.req_op[grant_id*3 +: 3];
      id_q <= grant_id;
      idx  <= SW'(NSLICE - 1);
      lt_q <= 1'b0;
      gt_q <= 1'b0;
    end else if (state == CMP) begin
`ifdef CMP_SCHED_EARLY_EXIT_EN
      if (sl_diff) begin
        lt_q <= (a_sl < b_sl);
        gt_q <= (a_sl > b_sl);
      end
`else
      // Keep only the most significant difference.
      if (sl_diff && !lt_q && !gt_q) begin
        lt_q <= (a_sl < b_sl);
        gt_q <= (a_sl > b_sl);
      end
`endif
      if (idx != '0) idx <= idx - 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_id     = '0;
    bus.rsp_result = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          bus.req_ready[grant_id] = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
`ifdef CMP_SCHED_EARLY_EXIT_EN
        if (sl_diff || idx == '0) state_nxt = RESP;
`else
        if (idx == '0) state_nxt = RESP;
`endif
      end
      RESP: begin
        bus.rsp_valid  = 1'b1;
        bus.rsp_id     = id_q;
        bus.rsp_result = decode(op_q, lt_q, gt_q);
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cmp_sched.sv
// Self-checking bench for cmp_sched: directed scenarios plus randomized
// requests, compared against a reference model of the arbitration order,
// comparison result and response latency.
module tb_cmp_sched;
  localparam int NREQ   = 4;
  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;
`ifdef CMP_SCHED_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  cmp_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rr_ptr = 0;

  logic [63:0] pa [NREQ];
  logic [63:0] pb [NREQ];
  logic        psa[NREQ];
  logic        psb[NREQ];
  logic [2:0]  pop[NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_result(input logic [63:0] a, input logic [63:0] b,
                                      input logic sa, input logic sb, input logic [2:0] op);
    logic lt, gt, eq;
    if (sa && sb) begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end else begin
      lt = a < b;
      gt = a > b;
    end
    eq = (a == b);
    case (op)
      3'd0:    return lt;
      3'd1:    return lt || eq;
      3'd2:    return gt;
      3'd3:    return gt || eq;
      3'd4:    return eq;
      3'd5:    return !eq;
      default: return 1'b0;
    endcase
  endfunction

  // Cycles from accept edge to rsp_valid visible: CMP cycles + 1.
  function automatic int ref_latency(input logic [63:0] a, input logic [63:0] b);
    int k;
    k = NSLICE;
    for (int s = 0; s < NSLICE; s++) begin
      if (a[(NSLICE-1-s)*SLICE +: SLICE] != b[(NSLICE-1-s)*SLICE +: SLICE]) begin
        k = s + 1;
        break;
      end
    end
    return (EARLY ? k : NSLICE) + 1;
  endfunction

  function automatic int pick(input logic [3:0] mask);
    for (int off = 0; off < NREQ; off++)
      if (mask[(rr_ptr + off) % NREQ]) return (rr_ptr + off) % NREQ;
    return 0;
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = pa[i];
      bus.req_b[i*WIDTH +: WIDTH] = pb[i];
      bus.req_a_signed[i]         = psa[i];
      bus.req_b_signed[i]         = psb[i];
      bus.req_op[i*3 +: 3]        = pop[i];
    end
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic sa, input logic sb, input logic [2:0] op);
    pa[i] = a; pb[i] = b; psa[i] = sa; psb[i] = sb; pop[i] = op;
  endtask

  task automatic randomize_req(input int i);
    int mode;
    mode   = $urandom_range(0, 3);
    pa[i]  = {$urandom, $urandom};
    case (mode)
      0: pb[i] = {$urandom, $urandom};
      1: pb[i] = pa[i];
      2: pb[i] = pa[i] ^ (64'd1 << $urandom_range(0, 63));
      default: begin
        pa[i] = 64'($signed($urandom_range(0, 15)) - 8);
        pb[i] = 64'($signed($urandom_range(0, 15)) - 8);
      end
    endcase
    psa[i] = 1'($urandom_range(0, 1));
    psb[i] = 1'($urandom_range(0, 1));
    pop[i] = 3'($urandom_range(0, 7));
  endtask

  // One full transaction: present mask, check grant, latency, response,
  // optional backpressure, and return to idle.
  task automatic serve(input logic [3:0] mask, input int bp, output logic [3:0] got);
    int g, n;
    logic [3:0] exp_rdy;
    g = pick(mask);
    exp_rdy = 4'b0001 << g;
    @(negedge clk);
    drive_payload();
    bus.req_valid = mask;
    bus.rsp_ready = (bp == 0);
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    got = bus.req_ready;
    chk("grant", 64'(got), 64'(exp_rdy));
    rr_ptr = (g + 1) % NREQ;
    @(posedge clk); #1;
    bus.req_valid = '0;
    n = 1;
    while (!bus.rsp_valid && n < 4 * NSLICE) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(ref_latency(pa[g], pb[g])));
    chk("rsp_id", 64'(bus.rsp_id), 64'(g));
    chk("rsp_result", 64'(bus.rsp_result), 64'(ref_result(pa[g], pb[g], psa[g], psb[g], pop[g])));
    if (bp > 0) begin
      bus.req_valid = '1;
      for (int c = 0; c < bp; c++) begin
        @(posedge clk); #1;
        chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp_id", 64'(bus.rsp_id), 64'(g));
        chk("bp_result", 64'(bus.rsp_result), 64'(ref_result(pa[g], pb[g], psa[g], psb[g], pop[g])));
        chk("bp_no_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("idle_after_hs", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    rr_ptr = 0;
  endtask

  // Grant req2 with equal operands, then reset while it is still in CMP.
  task automatic reset_in_flight();
    set_req(2, 64'hABCD, 64'hABCD, 1'b0, 1'b0, 3'd4);
    @(negedge clk);
    drive_payload();
    bus.req_valid = 4'b0100;
    #1;
    chk("inflight_grant", 64'(bus.req_ready), 64'h4);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_drop_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rr_ptr = 0;
    for (int c = 0; c < NSLICE + 2; c++) begin
      @(posedge clk); #1;
      chk("rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
  endtask

  logic [3:0] got;

  initial begin
    rst              = 1'b1;
    bus.req_valid    = '0;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.req_a_signed = '0;
    bus.req_b_signed = '0;
    bus.req_op       = '0;
    bus.rsp_ready    = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 64'd0, 64'd0, 1'b0, 1'b0, 3'd0);

    // Reset state, with requests pending that must not be granted.
    repeat (2) @(posedge clk);
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    bus.req_valid = '0;
    do_reset(1);

    // Unsigned LT.
    set_req(0, 64'd5, 64'd7, 1'b0, 1'b0, 3'd0);
    serve(4'b0001, 0, got);
    // Mixed signedness -> unsigned compare.
    set_req(0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 3'd0);
    serve(4'b0001, 0, got);
    // Both signed: 1 > -1.
    set_req(0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 3'd2);
    serve(4'b0001, 0, got);
    // Equality and reserved opcode.
    set_req(0, 64'h1234, 64'h1234, 1'b0, 1'b0, 3'd4);
    serve(4'b0001, 0, got);
    set_req(0, 64'h1234, 64'h1234, 1'b0, 1'b0, 3'd6);
    serve(4'b0001, 0, got);

    // Round robin from a fresh pointer.
    do_reset(1);
    for (int i = 0; i < NREQ; i++) randomize_req(i);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_order;
      exp_order = 4'b0001 << (i % NREQ);
      serve(4'b1111, 0, got);
      chk("rr_order", 64'(got), 64'(exp_order));
    end

    // Backpressure in RESP.
    set_req(3, 64'hFFFF_0000_0000_0001, 64'hFFFF_0000_0000_0002, 1'b0, 1'b0, 3'd1);
    serve(4'b1000, 10, got);

    // Reset mid-operation, then req1/req2 contend.
    reset_in_flight();
    for (int i = 0; i < NREQ; i++) randomize_req(i);
    serve(4'b0110, 0, got);
    chk("post_rst_first", 64'(got), 64'h2);
    // Pointer must return to 0: with req0/req3 pending, req0 wins.
    reset_in_flight();
    serve(4'b1001, 0, got);
    chk("post_rst_ptr0", 64'(got), 64'h1);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      logic [3:0] mask;
      int bp;
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) randomize_req(i);
      bp = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      serve(mask, bp, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cmp_sched.md
Name: cmp_sched

Overview:
Round-robin scheduler that shares one slice-serial magnitude/equality comparator between NREQ requesters.
- Each request carries two operands, per-operand signedness flags and a relational opcode.
- The block arbitrates, captures the winner's operands, compares SLICE bits per cycle from MSB down, then returns a 1-bit result tagged with the requester id.
- Sits between the ALU-side requesters and the result writeback; replaces NREQ full-width comparators.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 64, operand width in bits.
- SLICE, 16, bits compared per cycle. WIDTH must be a multiple of SLICE. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  input  NREQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing.
- req_a_signed  input  NREQ  operand A is signed.
- req_b_signed  input  NREQ  operand B is signed.
- req_op  input  NREQ*3  opcode: 0 LT, 1 LE, 2 GT, 3 GE, 4 EQ, 5 NE, 6/7 reserved.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  $clog2(NREQ)  index of the requester that issued the request.
- rsp_result  output  1  comparison result.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, state=IDLE, round-robin pointer=0 (requester 0 has highest priority).
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - Grant goes to the first valid requester at or after the pointer, wrapping modulo NREQ.
  - req_ready[g] is driven combinationally high in that same cycle.
  - On that cycle: latch operands, flags and op; set pointer=g+1 (mod NREQ); set slice index=NSLICE-1; go to CMP.
  - No valid requester: stay in IDLE, all req_ready low.
- Signedness rule: the comparison is signed only if both flags are 1; otherwise both operands are treated as unsigned.
  - Signed mode inverts bit WIDTH-1 of both operands before the compare.
  - Comparison is then unsigned per slice.
- CMP:
  - Each cycle compares the current slice of A and B.
  - Slices differ: record lt/gt.
  - Slices equal and index is 0: record eq.
  - Otherwise decrement the index.
  - Exit to RESP as defined under Optional Feature.
- RESP:
  - rsp_valid=1.
  - rsp_result is decoded from lt/eq/gt and op; ops 6/7 always give 0.
  - rsp_id and rsp_result stay stable while rsp_valid=1 and rsp_ready=0.
  - Handshake (rsp_valid & rsp_ready): go to IDLE next cycle.
  - No request is accepted in RESP, so the minimum spacing between accepts is 1 + CMP cycles + 1.
- Latency: accept at cycle t, CMP occupies cycles t+1..t+k, rsp_valid rises at t+k+1.
- Requester rules:
  - A requester holds req_valid and its payload stable until req_ready is seen.
  - Dropping req_valid before grant is legal; the request is simply not served.
- Reset mid-operation: captured request is discarded, state returns to IDLE, rsp_valid drops in the cycle after rst is sampled, pointer returns to 0.

Optional Feature:
- Macro: CMP_SCHED_EARLY_EXIT_EN
- Defined: CMP exits at the first differing slice, so k = (number of leading equal slices) + 1, with k ≤ NSLICE.
- Undefined: CMP always runs exactly NSLICE cycles; the first difference found is retained; latency is constant at NSLICE+1 after accept.
- EQ/NE results and all rsp_result values are identical in both builds.

Test Plan:
- Unsigned LT, default params, early exit defined: req0 A=5, B=7, both flags 0, op=0 → rsp_id=0, rsp_result=1, rsp_valid rises 5 cycles after accept.
- Mixed signedness: A=1 (flag 0), B=64'hFFFF_FFFF_FFFF_FFFF (flag 1), op=0 → unsigned compare, result 1.
- Both signed: same A and B with both flags 1, op=2 (GT) → result 1; latency 2 cycles with early exit, 5 without.
- Round robin: all four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0, exactly one req_ready per grant.
- Backpressure: rsp_ready held low 10 cycles in RESP → rsp_id and rsp_result constant, no req_ready asserted; rsp_ready=1 → IDLE next cycle.
- Reset during CMP with req2 in flight → rsp_valid=0 the next cycle; with req1 and req2 both valid after reset, first grant goes to req1.
- Equality and reserved op: A=B=64'h1234, op=4 → result 1 after 4 CMP cycles in both builds; op=6 → result 0.
